// File: rtl/sseg_scan_capture.sv
// Captures the scanned an/sseg/dp display bus, deglitches each digit slot,
// decodes segments back to BCD and presents whole 4-digit frames on valid/ready.
module sseg_scan_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  input  logic        dp,
  output logic        frame_valid,
  input  logic        frame_rdy,
  output logic [15:0] digits,
  output logic [3:0]  dp_out,
  output logic        bad_seg,
  output logic        bad_an,
  output logic        overrun,
  output logic        stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  // Sample layout: {an[3:0], sseg[6:0], dp}
  logic [11:0]   r_samp;
  logic [11:0]   r_prev;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_state;
  logic [3:0]    r_mask;
  logic [15:0]   r_shadow;
  logic [3:0]    r_dp_shadow;
  logic [IW-1:0] r_idle;
  logic          r_valid;
  logic [15:0]   r_digits;
  logic [3:0]    r_dp_out;
  logic          r_bad_seg;
  logic          r_bad_an;
  logic          r_overrun;
  logic          r_stale;

  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;
  logic          w_changed;
  logic [CW-1:0] w_cnt_next;
  logic          w_blank;
  logic          w_onehot;
  logic [1:0]    w_slot;
  logic [1:0]    w_state_next;
  logic          w_accept;
  logic          w_an_err;
  logic [4:0]    w_dec;
  logic [15:0]   w_shadow_next;
  logic [3:0]    w_dp_shadow_next;
  logic [3:0]    w_mask_acc;
  logic          w_complete;
  logic [IW-1:0] w_idle_next;
  logic          w_timeout;

  // Returns {undecodable, digit}
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: seg_decode = {1'b0, 4'h0};
      7'b1111001: seg_decode = {1'b0, 4'h1};
      7'b0100100: seg_decode = {1'b0, 4'h2};
      7'b0110000: seg_decode = {1'b0, 4'h3};
      7'b0011001: seg_decode = {1'b0, 4'h4};
      7'b0010010: seg_decode = {1'b0, 4'h5};
      7'b0000010: seg_decode = {1'b0, 4'h6};
      7'b1111000: seg_decode = {1'b0, 4'h7};
      7'b0000000: seg_decode = {1'b0, 4'h8};
      7'b0010000: seg_decode = {1'b0, 4'h9};
      7'b1111111: seg_decode = {1'b0, 4'hA};
      default:    seg_decode = {1'b1, 4'hE};
    endcase
  endfunction

  assign w_an      = r_samp[11:8];
  assign w_seg     = r_samp[7:1];
  assign w_dp      = r_samp[0];
  assign w_changed = (r_samp != r_prev);
  assign w_blank   = (w_an == 4'hF);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_changed)
      w_cnt_next = CW'(1);
    else if (r_cnt != CW'(SETTLE))
      w_cnt_next = r_cnt + CW'(1);
  end

  always_comb begin
    w_onehot = 1'b1;
    w_slot   = 2'd0;
    case (w_an)
      4'b1110: w_slot = 2'd0;
      4'b1101: w_slot = 2'd1;
      4'b1011: w_slot = 2'd2;
      4'b0111: w_slot = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  // A changed sample (or any cycle in IDLE) re-evaluates the anodes from scratch
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_an_err     = 1'b0;
    if (r_state == S_IDLE || w_changed) begin
      if (w_onehot) begin
        w_state_next = S_WAIT;
      end else begin
        w_state_next = S_IDLE;
        w_an_err     = ~w_blank;
      end
    end else if (r_state == S_WAIT && w_cnt_next >= CW'(SETTLE)) begin
      w_accept     = 1'b1;
      w_state_next = S_HELD;
    end
  end

  assign w_dec = seg_decode(w_seg);

  always_comb begin
    w_shadow_next    = r_shadow;
    w_dp_shadow_next = r_dp_shadow;
    w_mask_acc       = r_mask;
    if (w_accept) begin
      w_shadow_next[{w_slot, 2'b00} +: 4] = w_dec[3:0];
      w_dp_shadow_next[w_slot]            = ~w_dp;
      w_mask_acc[w_slot]                  = 1'b1;
    end
  end

  assign w_complete = w_accept && (w_mask_acc == 4'hF);

  always_comb begin
    w_idle_next = r_idle;
    if (w_accept)
      w_idle_next = '0;
    else if (r_idle != IW'(TIMEOUT))
      w_idle_next = r_idle + IW'(1);
  end

  assign w_timeout = (w_idle_next == IW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_samp      <= 12'hFFF;
      r_prev      <= 12'hFFF;
      r_cnt       <= '0;
      r_state     <= S_IDLE;
      r_mask      <= 4'h0;
      r_shadow    <= 16'h0000;
      r_dp_shadow <= 4'h0;
      r_idle      <= '0;
      r_valid     <= 1'b0;
      r_digits    <= 16'h0000;
      r_dp_out    <= 4'h0;
      r_bad_seg   <= 1'b0;
      r_bad_an    <= 1'b0;
      r_overrun   <= 1'b0;
      r_stale     <= 1'b0;
    end else begin
      r_samp      <= {an, sseg, dp};
      r_prev      <= r_samp;
      r_cnt       <= w_cnt_next;
      r_state     <= w_state_next;
      r_shadow    <= w_shadow_next;
      r_dp_shadow <= w_dp_shadow_next;
      r_idle      <= w_idle_next;

      if (w_complete || w_timeout)
        r_mask <= 4'h0;
      else
        r_mask <= w_mask_acc;

      // A completing frame wins over a same-cycle handshake and keeps valid high
      if (w_complete) begin
        r_digits <= w_shadow_next;
        r_dp_out <= w_dp_shadow_next;
        r_valid  <= 1'b1;
        if (r_valid && !frame_rdy)
          r_overrun <= 1'b1;
      end else if (r_valid && frame_rdy) begin
        r_valid <= 1'b0;
      end

      if (w_complete)
        r_stale <= 1'b0;
      else if (w_timeout)
        r_stale <= 1'b1;

      if (w_accept && w_dec[4])
        r_bad_seg <= 1'b1;
      if (w_an_err)
        r_bad_an <= 1'b1;
    end
  end

  assign frame_valid = r_valid;
  assign digits      = r_digits;
  assign dp_out      = r_dp_out;
  assign bad_seg     = r_bad_seg;
  assign bad_an      = r_bad_an;
  assign overrun     = r_overrun;
  assign stale       = r_stale;

endmodule
